uart_cmd_ctrl: RTL

- Command sequencer between the UART frame receiver (UartSink) and the frame transmitter (UartSource).
- Takes each received 8-byte frame {opcode, address, data}, executes it against a single-port synchronous memory, and returns a response frame through UartSource.
- Handles one command at a time, with a one-deep pending buffer for a frame that arrives while a command is in flight.

---
 rtl/uart_cmd_ctrl_if.sv | 31 +++
 rtl/uart_cmd_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl_if.sv
// Signal bundle between the command sequencer and its UART receiver/transmitter and memory.
// master = sequencer side, slave = UART blocks, memory and status consumers.
interface uart_cmd_ctrl_if #(
    parameter int FW = 64,
    parameter int AW = 16,
    parameter int DW = 32
);
    logic          SINK_DONE;
    logic [FW-1:0] SINK_DATA;
    logic          FEN;
    logic [FW-1:0] FDATA;
    logic          SRC_DONE;
    logic [AW-1:0] MEM_ADDR;
    logic          MEM_WE;
    logic [DW-1:0] MEM_WDATA;
    logic          MEM_RE;
    logic [DW-1:0] MEM_RDATA;
    logic          BUSY;
    logic [15:0]   CMD_COUNT;
    logic [7:0]    DROP_COUNT;

    modport master (
        input  SINK_DONE, SINK_DATA, SRC_DONE, MEM_RDATA,
        output FEN, FDATA, MEM_ADDR, MEM_WE, MEM_WDATA, MEM_RE, BUSY, CMD_COUNT, DROP_COUNT
    );

    modport slave (
        output SINK_DONE, SINK_DATA, SRC_DONE, MEM_RDATA,
        input  FEN, FDATA, MEM_ADDR, MEM_WE, MEM_WDATA, MEM_RE, BUSY, CMD_COUNT, DROP_COUNT
    );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Executes received {op, addr, data} frames against a single-port memory and returns a response frame.
// One command in flight, one frame pending; excess frames are dropped and counted.
//
// state      | meaning
// S_IDLE     | waiting for a pending frame
// S_DECODE   | decode opcode and range-check address
// S_MEM_WR   | write strobe cycle
// S_MEM_RD   | read strobe cycle
// S_RD_WAIT  | capture read data
// S_SEND     | one-cycle FEN pulse
// S_WAIT_SRC | response held until SRC_DONE
module uart_cmd_ctrl #(
    parameter int          DWIDTH    = 8,
    parameter int          OPCDBYTE  = 2,
    parameter int          ADDRBYTE  = 2,
    parameter int          DATABYTE  = 4,
    parameter int unsigned MEM_DEPTH = 1024
) (
    input  logic            CLOCK,
    input  logic            RESET,
    uart_cmd_ctrl_if.master bus
);
    localparam int OW = OPCDBYTE * DWIDTH;
    localparam int AW = ADDRBYTE * DWIDTH;
    localparam int DW = DATABYTE * DWIDTH;
    localparam int FW = OW + AW + DW;

    localparam logic [OW-1:0] OP_WRITE = OW'(16'h0001);
    localparam logic [OW-1:0] OP_READ  = OW'(16'h0002);
    localparam logic [OW-1:0] OP_PING  = OW'(16'h0003);
    localparam logic [OW-1:0] OP_ACK   = OW'(16'h8000);
    localparam logic [OW-1:0] OP_RANGE = OW'(16'hFFFE);
    localparam logic [OW-1:0] OP_BAD   = OW'(16'hFFFF);

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_MEM_WR, S_MEM_RD, S_RD_WAIT, S_SEND, S_WAIT_SRC
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [FW-1:0] r_cmd;
    logic [FW-1:0] r_resp;
    logic [FW-1:0] r_pend_data;
    logic          r_pend_vld;
    logic [15:0]   r_cmd_count;
    logic [7:0]    r_drop_count;

    logic [OW-1:0] w_op;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic          w_in_range;
    logic          w_consume;
    logic          w_fen;
    logic          w_we;
    logic          w_re;
    logic          w_busy;
    logic [AW-1:0] w_mem_addr;
    logic [DW-1:0] w_mem_wdata;

    assign w_op       = r_cmd[FW-1 -: OW];
    assign w_addr     = r_cmd[DW +: AW];
    assign w_data     = r_cmd[DW-1:0];
    assign w_in_range = (32'(w_addr) < MEM_DEPTH);
    assign w_consume  = (r_state == S_IDLE) && r_pend_vld;

    always_ff @(posedge CLOCK) begin
        if (RESET) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (r_pend_vld) w_next = S_DECODE;
            S_DECODE: begin
                if (w_op == OP_WRITE && w_in_range)     w_next = S_MEM_WR;
                else if (w_op == OP_READ && w_in_range) w_next = S_MEM_RD;
                else                                    w_next = S_SEND;
            end
            S_MEM_WR:   w_next = S_SEND;
            S_MEM_RD:   w_next = S_RD_WAIT;
            S_RD_WAIT:  w_next = S_SEND;
            S_SEND:     w_next = S_WAIT_SRC;
            S_WAIT_SRC: if (bus.SRC_DONE) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_fen       = (r_state == S_SEND);
        w_we        = (r_state == S_MEM_WR);
        w_re        = (r_state == S_MEM_RD);
        w_busy      = (r_state != S_IDLE);
        w_mem_addr  = (w_we || w_re) ? w_addr : '0;
        w_mem_wdata = w_we ? w_data : '0;
    end

    // Pending buffer: a consume and a reload may coincide in the same cycle.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_pend_data  <= '0;
            r_pend_vld   <= 1'b0;
            r_cmd        <= '0;
            r_resp       <= '0;
            r_cmd_count  <= '0;
            r_drop_count <= '0;
        end else begin
            if (bus.SINK_DONE && (!r_pend_vld || w_consume)) begin
                r_pend_data <= bus.SINK_DATA;
                r_pend_vld  <= 1'b1;
            end else if (w_consume) begin
                r_pend_vld <= 1'b0;
            end else if (bus.SINK_DONE && r_drop_count != 8'hFF) begin
                r_drop_count <= r_drop_count + 8'd1;
            end

            if (w_consume) r_cmd <= r_pend_data;

            case (r_state)
                S_DECODE: begin
                    if (w_op == OP_PING)
                        r_resp <= r_cmd;
                    else if ((w_op == OP_WRITE || w_op == OP_READ) && w_in_range)
                        r_resp <= {w_op | OP_ACK, w_addr, w_data};
                    else if (w_op == OP_WRITE || w_op == OP_READ)
                        r_resp <= {OP_RANGE, w_addr, {DW{1'b0}}};
                    else
                        r_resp <= {OP_BAD, w_addr, {DW{1'b0}}};
                end
                S_RD_WAIT:  r_resp <= {w_op | OP_ACK, w_addr, bus.MEM_RDATA};
                S_WAIT_SRC: if (bus.SRC_DONE) r_cmd_count <= r_cmd_count + 16'd1;
                default: ;
            endcase
        end
    end

    assign bus.FEN        = w_fen;
    assign bus.FDATA      = r_resp;
    assign bus.MEM_ADDR   = w_mem_addr;
    assign bus.MEM_WE     = w_we;
    assign bus.MEM_WDATA  = w_mem_wdata;
    assign bus.MEM_RE     = w_re;
    assign bus.BUSY       = w_busy;
    assign bus.CMD_COUNT  = r_cmd_count;
    assign bus.DROP_COUNT = r_drop_count;
endmodule
